dac_hdr_sched: RTL and testbench
================================

// Module: dac_hdr_sched
// PURPOSE
//  Header-burst scheduler for the DAC transmit path in the dac_clk domain. Selects the tx request
//  source (ADC-synchronous or software), times bursts on a free-running period, issues one-cycle
//  hdr_tx starts to the memory/LFSR header datapath, waits for its done handshake, counts bursts,
//  and reports overruns and dropped requests.
// PARAMETERS
//  G_HDR_PD_W   24  width of period-minus-one field (period in dac_clk cycles)
//  G_HDR_QTY_W  16  width of header-quantity-minus-one field
//  G_STAT_W     32  width of statistics counters (STATS feature only)
// PORTS
//  dac_clk       in   1            sole clock
//  dac_rst       in   1            reset, asynchronous, active-high
//  pd_min1       in   G_HDR_PD_W   period - 1; quasi-static, retimed into dac_clk domain upstream
//  qty_min1      in   G_HDR_QTY_W  headers per group - 1
//  tx_always     in   1            level: restart groups back-to-back without a request
//  tx_unsync     in   1            1: request source = sw_req; 0: request source = sync_req
//  sync_req      in   1            level from ADC FIFO (adc-synchronous tx request)
//  sw_req        in   1            level from register write (software tx request)
//  hdr_done      in   1            pulse from datapath: current header fully emitted
//  clr_status    in   1            pulse: clear sticky flags and counters
//  pd_tic        out  1            one-cycle pulse at period end
//  hdr_tx        out  1            one-cycle start pulse to header datapath
//  hdr_first     out  1            high with hdr_tx for header 0 of a group
//  hdr_last      out  1            high with hdr_tx for header qty_min1 of a group
//  txing         out  1            high from group accept until final hdr_done
//  hdr_idx       out  G_HDR_QTY_W  index of header currently in flight
//  overrun       out  1            sticky: pd_tic seen while header still in flight
//  req_drop      out  1            sticky: request edge arrived while txing
//  frames_sent   out  G_STAT_W     headers completed (STATS feature)
//  overrun_cnt   out  G_STAT_W     overrun events (STATS feature)
// BEHAVIOUR
//  - Reset: all outputs 0; pd counter 0; FSM IDLE; request edge register 0.
//  - Period counter: increments every cycle; pd_tic=1 and wrap to 0 when cnt>=pd_min1 (>= so a
//    reduced pd_min1 wraps next cycle). Free-running; unaffected by FSM. pd_min1=0 -> tic every cycle.
//  - Request: src=tx_unsync?sw_req:sync_req; req_edge = src & ~src_d (registered, 1-cycle latency).
//    Switching tx_unsync must not fabricate an edge: src_d is reloaded from the new source on switch.
//  - FSM: IDLE -> ARMED on req_edge or tx_always. ARMED -> SEND on pd_tic.
//    SEND: the tic cycle's next edge drives hdr_tx=1 (one cycle); hdr_first=(hdr_idx==0);
//    hdr_last=(hdr_idx==qty_min1); -> WAIT. WAIT: on hdr_done, if hdr_idx==qty_min1 -> DONE,
//    else hdr_idx+1 -> GAP. GAP -> SEND on next pd_tic. DONE: txing=0, hdr_idx=0; -> ARMED if
//    tx_always else IDLE (one cycle).
//  - txing=1 in ARMED(after accept), SEND, WAIT, GAP; 0 in IDLE and DONE.
//  - hdr_done and pd_tic same cycle in WAIT: done is taken, tic is not an overrun, next header waits
//    for the following tic. pd_tic in WAIT without hdr_done: overrun<=1, slot skipped.
//  - hdr_done outside WAIT: ignored.
//  - req_edge while txing: req_drop<=1, request discarded (not queued).
//  - tx_always deasserted mid-group: group completes, then IDLE.
//  - qty_min1 sampled at group accept; changes mid-group have no effect until next group.
//  - clr_status and a set event same cycle: set wins.
//  - dac_rst mid-group: immediate return to reset state, no further hdr_tx.
// CONFIGURATION
//  DAC_HDR_SCHED_STATS_EN defined: frames_sent +1 per accepted hdr_done in WAIT; overrun_cnt +1 per
//    overrun event; both saturate at all-ones; cleared by clr_status.
//  Not defined: frames_sent and overrun_cnt tied to 0; no counter logic synthesised.
// TESTING
//  1 pd_min1=9, qty_min1=2, tx_unsync=1, sw_req 0->1, hdr_done 3 cyc after each hdr_tx -> 3 hdr_tx
//    spaced 10 cycles; hdr_first on #1, hdr_last on #3; txing falls after 3rd done; frames_sent=3.
//  2 pd_min1=4, qty_min1=1, hdr_done held off 7 cycles -> overrun=1, overrun_cnt=1, 2nd hdr_tx at
//    first tic after done; clr_status -> overrun=0, counters 0.
//  3 tx_unsync=0, sync_req pulsed during group, sw_req toggled -> only sync_req starts groups;
//    mid-group edge sets req_drop, no extra group.
//  4 tx_always=1, qty_min1=0, pd_min1=3, immediate done -> hdr_tx every 4 cycles, each with
//    hdr_first=hdr_last=1; drop tx_always -> stops after current header.
//  5 dac_rst asserted in WAIT with hdr_idx=1 -> all outputs 0 asynchronously; after release no
//    hdr_tx until new request edge.
//  6 pd_min1 changed 20->3 while counter at 12 -> pd_tic next cycle, then every 4 cycles.

Source files
------------

// File: rtl/dac_hdr_sched_if.sv
// dac_hdr_sched_if: handshake between the header scheduler and the memory/LFSR header datapath.
//   hdr_tx     scheduler -> datapath  one-cycle start pulse for one header
//   hdr_first  scheduler -> datapath  qualifies hdr_tx: header 0 of a group
//   hdr_last   scheduler -> datapath  qualifies hdr_tx: final header of a group
//   hdr_idx    scheduler -> datapath  index of the header currently in flight
//   hdr_done   datapath -> scheduler  pulse: current header fully emitted
// Modports: master = scheduler side, slave = datapath side.
interface dac_hdr_sched_if #(
    parameter int unsigned G_HDR_QTY_W = 16
) ();
    logic                   hdr_tx;
    logic                   hdr_first;
    logic                   hdr_last;
    logic [G_HDR_QTY_W-1:0] hdr_idx;
    logic                   hdr_done;

    modport master (
        output hdr_tx,
        output hdr_first,
        output hdr_last,
        output hdr_idx,
        input  hdr_done
    );

    modport slave (
        input  hdr_tx,
        input  hdr_first,
        input  hdr_last,
        input  hdr_idx,
        output hdr_done
    );
endinterface

// File: rtl/dac_hdr_sched.sv
// dac_hdr_sched: header-burst scheduler for the DAC transmit path (dac_clk domain).
// Selects the tx request source, times bursts on a free-running period, issues one-cycle header
// starts to the datapath, waits for each done, and flags overruns and dropped requests.
// Ports:
//   dac_clk, dac_rst   clock; asynchronous active-high reset
//   pd_min1            period - 1 in dac_clk cycles (quasi-static)
//   qty_min1           headers per group - 1, sampled at group accept
//   tx_always          restart groups back-to-back without a request
//   tx_unsync          request source select: 1 = sw_req, 0 = sync_req
//   sync_req, sw_req   request levels (rising edge starts a group)
//   clr_status         pulse: clear sticky flags and counters
//   pd_tic             one-cycle pulse at period end
//   txing              group in progress
//   overrun, req_drop  sticky status flags
//   frames_sent        headers completed (statistics build only, else 0)
//   overrun_cnt        overrun events (statistics build only, else 0)
//   hdr                datapath handshake (dac_hdr_sched_if.master)
// Optional feature: define DAC_HDR_SCHED_STATS_EN to build the saturating statistics counters.
module dac_hdr_sched #(
    parameter int unsigned G_HDR_PD_W  = 24,
    parameter int unsigned G_HDR_QTY_W = 16,
    parameter int unsigned G_STAT_W    = 32
) (
    input  logic                   dac_clk,
    input  logic                   dac_rst,
    input  logic [G_HDR_PD_W-1:0]  pd_min1,
    input  logic [G_HDR_QTY_W-1:0] qty_min1,
    input  logic                   tx_always,
    input  logic                   tx_unsync,
    input  logic                   sync_req,
    input  logic                   sw_req,
    input  logic                   clr_status,
    output logic                   pd_tic,
    output logic                   txing,
    output logic                   overrun,
    output logic                   req_drop,
    output logic [G_STAT_W-1:0]    frames_sent,
    output logic [G_STAT_W-1:0]    overrun_cnt,
    dac_hdr_sched_if.master        hdr
);
    typedef enum logic [2:0] {StIdle, StArmed, StSend, StWait, StGap, StDone} state_e;

    localparam logic [G_HDR_PD_W-1:0]  PdOne  = {{(G_HDR_PD_W-1){1'b0}}, 1'b1};
    localparam logic [G_HDR_QTY_W-1:0] IdxOne = {{(G_HDR_QTY_W-1){1'b0}}, 1'b1};

    state_e                 state_q, state_d;
    logic [G_HDR_PD_W-1:0]  cnt_q;
    logic                   tic_q;
    logic                   src, src_d_q, unsync_q, req_edge_q;
    logic [G_HDR_QTY_W-1:0] qty_q, idx_q;
    logic                   overrun_q, req_drop_q;
    logic                   is_last, accept, done_ok, ovr_ev, drop_ev;
    logic                   send, busy;

    // Free-running period counter; >= so a lowered pd_min1 wraps on the next edge.
    always_ff @(posedge dac_clk or posedge dac_rst) begin
        if (dac_rst) begin
            cnt_q <= '0;
            tic_q <= 1'b0;
        end else if (cnt_q >= pd_min1) begin
            cnt_q <= '0;
            tic_q <= 1'b1;
        end else begin
            cnt_q <= cnt_q + PdOne;
            tic_q <= 1'b0;
        end
    end

    // Request edge detect. The delayed copy always follows the currently selected source, and
    // the cycle in which the selection changes is masked, so a switch never looks like an edge.
    assign src = tx_unsync ? sw_req : sync_req;

    always_ff @(posedge dac_clk or posedge dac_rst) begin
        if (dac_rst) begin
            src_d_q    <= 1'b0;
            unsync_q   <= 1'b0;
            req_edge_q <= 1'b0;
        end else begin
            req_edge_q <= (tx_unsync == unsync_q) & src & ~src_d_q;
            src_d_q    <= src;
            unsync_q   <= tx_unsync;
        end
    end

    assign is_last = (idx_q == qty_q);

    always_ff @(posedge dac_clk or posedge dac_rst) begin
        if (dac_rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (req_edge_q || tx_always) state_d = StArmed;
            StArmed: if (tic_q) state_d = StSend;
            StSend:  state_d = StWait;
            StWait:  if (hdr.hdr_done) state_d = is_last ? StDone : StGap;
            StGap:   if (tic_q) state_d = StSend;
            // Not busy here, so a request edge landing in this cycle is accepted, not dropped.
            StDone:  state_d = (tx_always || req_edge_q) ? StArmed : StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        send = (state_q == StSend);
        busy = (state_q == StArmed) || (state_q == StSend) ||
               (state_q == StWait)  || (state_q == StGap);
    end

    assign hdr.hdr_tx    = send;
    assign hdr.hdr_first = send && (idx_q == '0);
    assign hdr.hdr_last  = send && is_last;
    assign hdr.hdr_idx   = idx_q;
    assign txing         = busy;
    assign pd_tic        = tic_q;
    assign overrun       = overrun_q;
    assign req_drop      = req_drop_q;

    assign accept  = ((state_q == StIdle) || (state_q == StDone)) && (state_d == StArmed);
    assign done_ok = (state_q == StWait) && hdr.hdr_done;
    // A tic coinciding with done is not an overrun; the next header waits for the following tic.
    assign ovr_ev  = (state_q == StWait) && tic_q && !hdr.hdr_done;
    assign drop_ev = req_edge_q && busy;

    always_ff @(posedge dac_clk or posedge dac_rst) begin
        if (dac_rst) begin
            qty_q <= '0;
            idx_q <= '0;
        end else if (accept) begin
            qty_q <= qty_min1;
            idx_q <= '0;
        end else if (done_ok) begin
            idx_q <= is_last ? '0 : idx_q + IdxOne;
        end
    end

    // Sticky flags: a set in the same cycle as clr_status wins.
    always_ff @(posedge dac_clk or posedge dac_rst) begin
        if (dac_rst) begin
            overrun_q  <= 1'b0;
            req_drop_q <= 1'b0;
        end else begin
            overrun_q  <= ovr_ev  | (overrun_q  & ~clr_status);
            req_drop_q <= drop_ev | (req_drop_q & ~clr_status);
        end
    end

`ifdef DAC_HDR_SCHED_STATS_EN
    localparam logic [G_STAT_W-1:0] StatOne = {{(G_STAT_W-1){1'b0}}, 1'b1};

    logic [G_STAT_W-1:0] frames_q, ovr_cnt_q;

    // Saturating counters; an increment together with clr_status leaves the count at one.
    always_ff @(posedge dac_clk or posedge dac_rst) begin
        if (dac_rst) begin
            frames_q  <= '0;
            ovr_cnt_q <= '0;
        end else begin
            if (done_ok) begin
                if (clr_status)          frames_q <= StatOne;
                else if (frames_q != '1) frames_q <= frames_q + StatOne;
            end else if (clr_status) begin
                frames_q <= '0;
            end
            if (ovr_ev) begin
                if (clr_status)           ovr_cnt_q <= StatOne;
                else if (ovr_cnt_q != '1) ovr_cnt_q <= ovr_cnt_q + StatOne;
            end else if (clr_status) begin
                ovr_cnt_q <= '0;
            end
        end
    end

    assign frames_sent = frames_q;
    assign overrun_cnt = ovr_cnt_q;
`else
    assign frames_sent = '0;
    assign overrun_cnt = '0;
`endif
endmodule

// File: tb/tb_dac_hdr_sched.sv
`timescale 1ns/1ps
module tb_dac_hdr_sched;
    localparam int unsigned PD_W   = 24;
    localparam int unsigned QTY_W  = 16;
    localparam int unsigned STAT_W = 32;
`ifdef DAC_HDR_SCHED_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic              dac_clk    = 1'b0;
    logic              dac_rst    = 1'b1;
    logic [PD_W-1:0]   pd_min1    = '0;
    logic [QTY_W-1:0]  qty_min1   = '0;
    logic              tx_always  = 1'b0;
    logic              tx_unsync  = 1'b0;
    logic              sync_req   = 1'b0;
    logic              sw_req     = 1'b0;
    logic              clr_status = 1'b0;
    logic              pd_tic, txing, overrun, req_drop;
    logic [STAT_W-1:0] frames_sent, overrun_cnt;

    dac_hdr_sched_if #(.G_HDR_QTY_W(QTY_W)) hdr_bus ();

    dac_hdr_sched #(
        .G_HDR_PD_W (PD_W),
        .G_HDR_QTY_W(QTY_W),
        .G_STAT_W   (STAT_W)
    ) dut (
        .dac_clk    (dac_clk),
        .dac_rst    (dac_rst),
        .pd_min1    (pd_min1),
        .qty_min1   (qty_min1),
        .tx_always  (tx_always),
        .tx_unsync  (tx_unsync),
        .sync_req   (sync_req),
        .sw_req     (sw_req),
        .clr_status (clr_status),
        .pd_tic     (pd_tic),
        .txing      (txing),
        .overrun    (overrun),
        .req_drop   (req_drop),
        .frames_sent(frames_sent),
        .overrun_cnt(overrun_cnt),
        .hdr        (hdr_bus)
    );

    always #5 dac_clk = ~dac_clk;

    typedef struct {
        logic [PD_W-1:0]  pd;
        logic [QTY_W-1:0] qty;
        int               d_first;  // hdr_done delay after hdr_tx for header 0
        int               d_rest;   // hdr_done delay for later headers
        int               exp_tx;
        int               exp_gap;
        int               exp_ovr;
    } scen_t;

    scen_t scen [4];

    int n_pass = 0, n_checks = 0;
    int cyc = 0, tx_cnt = 0, last_tx_cyc = 0, last_done_cyc = 0, fall_cyc = 0, cd = 0;
    int d_first = 3, d_rest = 3, mon_q = 0, exp_gap = 0;
    bit txing_prev = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // One clock: sample #1 after the edge, model the datapath's done response, check each start.
    task automatic tick();
        int pos;
        @(posedge dac_clk);
        #1;
        cyc++;
        hdr_bus.hdr_done = 1'b0;
        if (cd > 0) begin
            cd--;
            if (cd == 0) begin
                hdr_bus.hdr_done = 1'b1;
                last_done_cyc = cyc;
            end
        end
        if (hdr_bus.hdr_tx) begin
            pos = tx_cnt % (mon_q + 1);
            check($sformatf("tx%0d_idx", tx_cnt), 64'(hdr_bus.hdr_idx), 64'(pos));
            check($sformatf("tx%0d_first", tx_cnt), 64'(hdr_bus.hdr_first), 64'(pos == 0));
            check($sformatf("tx%0d_last", tx_cnt), 64'(hdr_bus.hdr_last), 64'(pos == mon_q));
            if (tx_cnt > 0)
                check($sformatf("tx%0d_gap", tx_cnt), 64'(cyc - last_tx_cyc), 64'(exp_gap));
            last_tx_cyc = cyc;
            cd = (tx_cnt == 0) ? d_first : d_rest;
            tx_cnt++;
        end
        if (txing_prev && !txing) fall_cyc = cyc;
        txing_prev = txing;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic mon_reset();
        tx_cnt = 0;
        fall_cyc = -1;
        last_done_cyc = -100;
        cd = 0;
        txing_prev = txing;
    endtask

    task automatic pulse_clr();
        clr_status = 1'b1;
        tick();
        clr_status = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_pd_tic"},    64'(pd_tic), 64'(0));
        check({tag, "_hdr_tx"},    64'(hdr_bus.hdr_tx), 64'(0));
        check({tag, "_hdr_first"}, 64'(hdr_bus.hdr_first), 64'(0));
        check({tag, "_hdr_last"},  64'(hdr_bus.hdr_last), 64'(0));
        check({tag, "_hdr_idx"},   64'(hdr_bus.hdr_idx), 64'(0));
        check({tag, "_txing"},     64'(txing), 64'(0));
        check({tag, "_overrun"},   64'(overrun), 64'(0));
        check({tag, "_req_drop"},  64'(req_drop), 64'(0));
        check({tag, "_frames"},    64'(frames_sent), 64'(0));
        check({tag, "_ovr_cnt"},   64'(overrun_cnt), 64'(0));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        hdr_bus.hdr_done = 1'b0;
        // pd, qty, done delays, expected starts / spacing / overruns
        scen[0] = '{pd: 24'd9, qty: 16'd2, d_first: 3, d_rest: 3, exp_tx: 3, exp_gap: 10, exp_ovr: 0};
        scen[1] = '{pd: 24'd4, qty: 16'd1, d_first: 7, d_rest: 2, exp_tx: 2, exp_gap: 10, exp_ovr: 1};
        scen[2] = '{pd: 24'd4, qty: 16'd3, d_first: 2, d_rest: 2, exp_tx: 4, exp_gap: 5,  exp_ovr: 0};
        // done lands on the tic: no overrun, next header waits one more period
        scen[3] = '{pd: 24'd4, qty: 16'd1, d_first: 4, d_rest: 1, exp_tx: 2, exp_gap: 10, exp_ovr: 0};

        #12;
        check_zero("reset");
        @(posedge dac_clk);
        #1;
        dac_rst = 1'b0;

        // Period counter: 21-cycle period, then pd_min1 lowered 20 -> 3 with the counter at 12.
        pd_min1 = 24'd20;
        for (int i = 0; i < 40 && !pd_tic; i++) tick();
        check("pd_tic_found", 64'(pd_tic), 64'(1));
        for (int j = 1; j <= 21; j++) begin
            tick();
            check($sformatf("pd21_c%0d", j), 64'(pd_tic), 64'(j == 21));
        end
        for (int j = 1; j <= 21; j++) begin
            tick();
            check($sformatf("pdchg_c%0d", j), 64'(pd_tic), 64'(j == 13 || j == 17 || j == 21));
            if (j == 12) pd_min1 = 24'd3;
        end
        pd_min1 = 24'd0;
        for (int j = 1; j <= 5; j++) begin
            tick();
            check($sformatf("pd0_c%0d", j), 64'(pd_tic), 64'(1));
        end

        // Software-requested groups from the table.
        for (int i = 0; i < 4; i++) begin
            pd_min1   = scen[i].pd;
            qty_min1  = scen[i].qty;
            tx_unsync = 1'b1;
            sw_req    = 1'b0;
            d_first   = scen[i].d_first;
            d_rest    = scen[i].d_rest;
            mon_q     = int'(scen[i].qty);
            exp_gap   = scen[i].exp_gap;
            ticks(3);
            mon_reset();
            sw_req = 1'b1;
            ticks(150);
            check($sformatf("s%0d_tx_count", i), 64'(tx_cnt), 64'(scen[i].exp_tx));
            check($sformatf("s%0d_txing_fall", i), 64'(fall_cyc), 64'(last_done_cyc + 1));
            check($sformatf("s%0d_txing", i), 64'(txing), 64'(0));
            check($sformatf("s%0d_overrun", i), 64'(overrun), 64'(scen[i].exp_ovr > 0));
            check($sformatf("s%0d_ovr_cnt", i), 64'(overrun_cnt),
                  64'(STATS ? scen[i].exp_ovr : 0));
            check($sformatf("s%0d_frames", i), 64'(frames_sent), 64'(STATS ? scen[i].exp_tx : 0));
            check($sformatf("s%0d_req_drop", i), 64'(req_drop), 64'(0));
            sw_req = 1'b0;
            pulse_clr();
            check($sformatf("s%0d_clr_overrun", i), 64'(overrun), 64'(0));
            check($sformatf("s%0d_clr_frames", i), 64'(frames_sent), 64'(0));
            check($sformatf("s%0d_clr_ovr_cnt", i), 64'(overrun_cnt), 64'(0));
        end

        // ADC-synchronous source: sw_req and source switching must not start anything.
        pd_min1 = 24'd9;
        qty_min1 = 16'd1;
        tx_unsync = 1'b0;
        d_first = 3;
        d_rest = 3;
        mon_q = 1;
        exp_gap = 10;
        ticks(3);
        mon_reset();
        sw_req = 1'b1;
        ticks(30);
        check("sync_sw_ignored", 64'(tx_cnt), 64'(0));
        tx_unsync = 1'b1;
        ticks(30);
        check("switch_no_edge", 64'(tx_cnt), 64'(0));
        tx_unsync = 1'b0;
        ticks(5);
        sw_req = 1'b0;
        sync_req = 1'b1;
        tick();
        sync_req = 1'b0;
        for (int i = 0; i < 40 && tx_cnt < 1; i++) tick();
        check("sync_start", 64'(tx_cnt), 64'(1));
        check("sync_no_drop_yet", 64'(req_drop), 64'(0));
        tick();
        sw_req = 1'b1;
        sync_req = 1'b1;
        tick();
        sync_req = 1'b0;
        sw_req = 1'b0;
        ticks(60);
        check("sync_tx_count", 64'(tx_cnt), 64'(2));
        check("sync_req_drop", 64'(req_drop), 64'(1));
        check("sync_txing_end", 64'(txing), 64'(0));

        // Back-to-back groups of one header; stop after the current header when tx_always drops.
        pulse_clr();
        tx_unsync = 1'b1;
        pd_min1 = 24'd3;
        qty_min1 = 16'd0;
        d_first = 1;
        d_rest = 1;
        mon_q = 0;
        exp_gap = 4;
        ticks(3);
        mon_reset();
        tx_always = 1'b1;
        for (int i = 0; i < 40 && tx_cnt < 3; i++) tick();
        check("always_reached3", 64'(tx_cnt), 64'(3));
        tx_always = 1'b0;
        ticks(20);
        check("always_stop", 64'(tx_cnt), 64'(3));
        check("always_txing", 64'(txing), 64'(0));
        check("always_no_drop", 64'(req_drop), 64'(0));

        // Reset while waiting on header 1.
        pulse_clr();
        pd_min1 = 24'd9;
        qty_min1 = 16'd2;
        d_first = 3;
        d_rest = 3;
        mon_q = 2;
        exp_gap = 10;
        ticks(3);
        mon_reset();
        sw_req = 1'b1;
        for (int i = 0; i < 60 && tx_cnt < 2; i++) tick();
        tick();
        check("prerst_idx", 64'(hdr_bus.hdr_idx), 64'(1));
        check("prerst_txing", 64'(txing), 64'(1));
        #2;
        dac_rst = 1'b1;
        #1;
        check_zero("midrst");
        cd = 0;
        hdr_bus.hdr_done = 1'b0;
        ticks(2);
        dac_rst = 1'b0;
        mon_reset();
        ticks(40);
        check("postrst_no_tx", 64'(tx_cnt), 64'(0));
        sw_req = 1'b0;
        ticks(2);
        sw_req = 1'b1;
        for (int i = 0; i < 30 && tx_cnt < 1; i++) tick();
        check("postrst_restart", 64'(tx_cnt), 64'(1));
        ticks(60);
        check("postrst_tx_count", 64'(tx_cnt), 64'(3));
        check("postrst_txing", 64'(txing), 64'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
